multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main control FSM of the multi-cycle MIPS core; sits directly upstream of the ALU control decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives the 2-bit alu_ct_op consumed by the ALU control decoder: 00 add, 01 sub, 10 decode funct.
- Drives all datapath mux selects, write enables and memory strobes, and stalls on a memory ready handshake.

Parameters:
- OP_WIDTH, 6, opcode field width.
- ST_WIDTH, 4, state register width.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  OP_WIDTH  instr[31:26] from the instruction register.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero.
- i_or_d  out  1  memory address select: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  register write data: 0 ALUOut, 1 MDR.
- reg_dst  out  1  destination select: 0 rt, 1 rd.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A: 0 PC, 1 rs.
- alu_src_b  out  2  ALU B: 00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- alu_ct_op  out  2  to the ALU control decoder.
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- instr_done  out  1  one-cycle pulse on the final cycle of each retired instruction.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- state  out  ST_WIDTH  current state, for debug.

Behaviour:
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDIU 001001. Anything else is illegal.
- States: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, ALU_WB 7, BRANCH 8, JUMP 9, IMM_EXEC 10, IMM_WB 11. Codes 12-15 are unreachable and go to FETCH.
- Reset: asynchronous; state becomes FETCH immediately. While rst=1, every output is 0 (state output reads 0). First fetch cycle is the first clk edge after rst deasserts.
- Unlisted outputs are 0 in every state. All outputs are decoded combinationally from state, plus mem_ready and op where stated.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ct_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ct_op=00. Next state by op:
  - LW/SW -> MEM_ADDR; R -> EXECUTE; BEQ -> BRANCH; J -> JUMP; ADDIU -> IMM_EXEC.
  - Illegal -> FETCH with illegal_op=1 this cycle.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_ct_op=00. Go to MEM_READ (LW) or MEM_WRITE (SW); op is held stable by the IR.
- MEM_READ: mem_read=1, i_or_d=1. Wait for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. instr_done=mem_ready. Wait for mem_ready, then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_ct_op=10. Next ALU_WB.
- ALU_WB: reg_dst=1, reg_write=1, mem_to_reg=0, instr_done=1. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_ct_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Next FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Next FETCH.
- IMM_EXEC: alu_src_a=1, alu_src_b=10, alu_ct_op=00. Next IMM_WB.
- IMM_WB: reg_dst=0, reg_write=1, mem_to_reg=0, instr_done=1. Next FETCH.
- Invariants:
  - mem_read and mem_write are never both 1.
  - reg_write and any PC write are never both 1.
  - instr_done is at most one cycle per instruction.
- Latency with mem_ready held 1 (cycles per instruction): R 4, ADDIU 4, LW 5, SW 4, BEQ 3, J 3. Every cycle mem_ready=0 in a wait state adds one.
- Reset mid-instruction abandons it; no instr_done is produced.

Decomposition:
- Shared package holds:
  - opcode constants;
  - state enum (ST_WIDTH encoding above);
  - alu_ct_op constants ALU_OP_ADD 00, ALU_OP_SUB 01, ALU_OP_FUNCT 10, shared with the ALU control decoder;
  - alu_src_b and pc_source select constants.
- Single module: state register plus next-state and output case blocks. No sub-module.

Test Plan:
- Reset: rst=1 mid-run -> all outputs 0 the same cycle. After release: state=0, mem_read=1, alu_src_b=01.
- R-type, op=000000, mem_ready=1 -> states 0,1,6,7. alu_ct_op=10 in EXECUTE. reg_dst=1 and reg_write=1 with instr_done=1 in cycle 4.
- LW, op=100011, mem_ready low 3 cycles in MEM_READ -> stays in state 3 for 3 extra cycles. Then MEM_WB with mem_to_reg=1 and reg_write=1; total 8 cycles.
- SW then BEQ:
  - SW: mem_write=1 with i_or_d=1 only in state 5, and instr_done coincides with mem_ready.
  - BEQ (op=000100): alu_ct_op=01, pc_write_cond=1, pc_source=01 in cycle 3.
- Illegal op=111111 -> illegal_op=1 for exactly one cycle in DECODE. Next state FETCH; no reg_write or PC write occurs.
- FETCH stall with mem_ready=0 for 5 cycles -> ir_write=pc_write=0 throughout. Both are 1 only on the cycle mem_ready rises.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control path.
// Holds opcode encodings, the main-FSM state codes, the alu_ct_op encoding
// shared with the ALU control decoder, and the datapath mux select codes.
package multicycle_ctrl_pkg;

  // Opcode field values (instr[31:26])
  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDIU = 6'b001001;

  // Main FSM state codes; 12-15 are unreachable
  localparam logic [3:0] ST_FETCH     = 4'd0;
  localparam logic [3:0] ST_DECODE    = 4'd1;
  localparam logic [3:0] ST_MEM_ADDR  = 4'd2;
  localparam logic [3:0] ST_MEM_READ  = 4'd3;
  localparam logic [3:0] ST_MEM_WB    = 4'd4;
  localparam logic [3:0] ST_MEM_WRITE = 4'd5;
  localparam logic [3:0] ST_EXECUTE   = 4'd6;
  localparam logic [3:0] ST_ALU_WB    = 4'd7;
  localparam logic [3:0] ST_BRANCH    = 4'd8;
  localparam logic [3:0] ST_JUMP      = 4'd9;
  localparam logic [3:0] ST_IMM_EXEC  = 4'd10;
  localparam logic [3:0] ST_IMM_WB    = 4'd11;

  // alu_ct_op encoding consumed by the ALU control decoder
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] ALUB_RT      = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core.
// Sequences each instruction through fetch/decode/execute/memory/writeback
// and decodes all datapath controls combinationally from the current state.
// Ports:
//   clk, rst        - core clock (rising edge), async active-high reset
//   op              - opcode from the instruction register
//   mem_ready       - memory completes the current access this cycle
//   pc_write(_cond) - unconditional / zero-conditional PC load
//   i_or_d          - memory address select (0 PC, 1 ALUOut)
//   mem_read/write  - memory strobes
//   ir_write        - instruction register load
//   mem_to_reg      - reg write data (0 ALUOut, 1 MDR)
//   reg_dst         - dest select (0 rt, 1 rd)
//   reg_write       - register file write enable
//   alu_src_a/b     - ALU operand selects
//   alu_ct_op       - to ALU control decoder (add/sub/funct)
//   pc_source       - PC source select
//   instr_done      - pulse on the last cycle of a retired instruction
//   illegal_op      - pulse in DECODE on an unsupported opcode
//   state           - current state, for debug
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned OP_WIDTH = 6,
  parameter int unsigned ST_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OP_WIDTH-1:0] op,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_ct_op,
  output logic [1:0]          pc_source,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [ST_WIDTH-1:0] state
);

  logic [ST_WIDTH-1:0] state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  // Next-state logic
  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:     state_d = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_R:         state_d = ST_EXECUTE;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDIU:     state_d = ST_IMM_EXEC;
          default:      state_d = ST_FETCH;
        endcase
      end
      // IR holds op stable, so it still distinguishes LW from SW here
      ST_MEM_ADDR:  state_d = (op == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  state_d = mem_ready ? ST_MEM_WB : ST_MEM_READ;
      ST_MEM_WB:    state_d = ST_FETCH;
      ST_MEM_WRITE: state_d = mem_ready ? ST_FETCH : ST_MEM_WRITE;
      ST_EXECUTE:   state_d = ST_ALU_WB;
      ST_ALU_WB:    state_d = ST_FETCH;
      ST_BRANCH:    state_d = ST_FETCH;
      ST_JUMP:      state_d = ST_FETCH;
      ST_IMM_EXEC:  state_d = ST_IMM_WB;
      ST_IMM_WB:    state_d = ST_FETCH;
      default:      state_d = ST_FETCH;
    endcase
  end

  // Output decode; everything is forced low while reset is held
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUB_RT;
    alu_ct_op     = ALU_OP_ADD;
    pc_source     = PCSRC_ALU;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = ALUB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        ST_DECODE: begin
          alu_src_b  = ALUB_IMM_SH2;
          illegal_op = !(op == OP_R  || op == OP_LW || op == OP_SW ||
                         op == OP_BEQ || op == OP_J || op == OP_ADDIU);
        end
        ST_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUB_IMM;
        end
        ST_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        ST_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        ST_MEM_WRITE: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        ST_EXECUTE: begin
          alu_src_a = 1'b1;
          alu_ct_op = ALU_OP_FUNCT;
        end
        ST_ALU_WB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        ST_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_ct_op     = ALU_OP_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          instr_done    = 1'b1;
        end
        ST_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = PCSRC_JUMP;
          instr_done = 1'b1;
        end
        ST_IMM_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUB_IMM;
        end
        ST_IMM_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. Each scenario pushes the per-cycle
// stimulus and expected output vector onto queues, then drains them cycle by
// cycle, comparing the DUT outputs against the popped expectation.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, aop, pcs;
    logic       done, ill;
  } out_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_ct_op, pc_source;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  out_t exp_q[$];
  logic mr_q[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.OP_WIDTH(6), .ST_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ct_op(alu_ct_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  function automatic out_t cur();
    out_t o;
    o = '{st: state, pcw: pc_write, pcwc: pc_write_cond, iord: i_or_d, mrd: mem_read,
          mwr: mem_write, irw: ir_write, m2r: mem_to_reg, rdst: reg_dst, rw: reg_write,
          asa: alu_src_a, asb: alu_src_b, aop: alu_ct_op, pcs: pc_source,
          done: instr_done, ill: illegal_op};
    return o;
  endfunction

  // Expected outputs for one cycle, written out from the state table
  function automatic out_t expect_of(input logic [3:0] st, input logic mr, input logic ill);
    out_t e;
    e = '0;
    e.st = st;
    case (st)
      4'd0:  begin e.mrd = 1; e.asb = 2'b01; e.irw = mr; e.pcw = mr; end
      4'd1:  begin e.asb = 2'b11; e.ill = ill; end
      4'd2:  begin e.asa = 1; e.asb = 2'b10; end
      4'd3:  begin e.mrd = 1; e.iord = 1; end
      4'd4:  begin e.rw = 1; e.m2r = 1; e.done = 1; end
      4'd5:  begin e.mwr = 1; e.iord = 1; e.done = mr; end
      4'd6:  begin e.asa = 1; e.aop = 2'b10; end
      4'd7:  begin e.rdst = 1; e.rw = 1; e.done = 1; end
      4'd8:  begin e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.pcs = 2'b01; e.done = 1; end
      4'd9:  begin e.pcw = 1; e.pcs = 2'b10; e.done = 1; end
      4'd10: begin e.asa = 1; e.asb = 2'b10; end
      4'd11: begin e.rw = 1; e.done = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic push(input logic [3:0] st, input logic mr, input logic ill = 1'b0);
    exp_q.push_back(expect_of(st, mr, ill));
    mr_q.push_back(mr);
  endtask

  task automatic test_reset();
    out_t got;
    rst = 1'b1; mem_ready = 1'b1; op = 6'b000000;
    @(negedge clk);
    #1;
    got = cur();
    total++;
    if (got !== '0) begin
      bad++; $display("FAIL reset_poweron: got %h want %h", got, out_t'('0));
    end
    @(negedge clk);
    rst = 1'b0;
    // Run into EXECUTE of an R-type, then reset mid-instruction
    push(4'd0, 1'b1); push(4'd1, 1'b1);
    while (exp_q.size() > 0) begin
      mem_ready = mr_q.pop_front();
      #1;
      got = cur();
      total++;
      if (got !== exp_q[0]) begin
        bad++; $display("FAIL reset_pre: got %h want %h", got, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    total++;
    if (state !== 4'd6) begin
      bad++; $display("FAIL reset_midstate: got %0d want 6", state);
    end
    rst = 1'b1;
    #1;
    got = cur();
    total++;
    if (got !== '0) begin
      bad++; $display("FAIL reset_mid: got %h want %h", got, out_t'('0));
    end
    @(negedge clk);
    got = cur();
    total++;
    if (got !== '0) begin
      bad++; $display("FAIL reset_hold: got %h want %h", got, out_t'('0));
    end
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    got = cur();
    total++;
    if (got !== expect_of(4'd0, 1'b0, 1'b0)) begin
      bad++; $display("FAIL reset_release: got %h want %h", got, expect_of(4'd0, 1'b0, 1'b0));
    end
    @(negedge clk);
  endtask

  task automatic test_instr(input string name, input logic [5:0] opc);
    out_t got;
    int   cyc = 0;
    op = opc;
    while (exp_q.size() > 0) begin
      mem_ready = mr_q.pop_front();
      #1;
      got = cur();
      total++;
      if (got !== exp_q[0]) begin
        bad++; $display("FAIL %s cyc%0d: got %h want %h", name, cyc, got, exp_q[0]);
      end
      void'(exp_q.pop_front());
      total++;
      if ((mem_read && mem_write) || (reg_write && (pc_write || pc_write_cond))) begin
        bad++;
        $display("FAIL %s_invariant cyc%0d: got rd=%b wr=%b rw=%b pcw=%b pcwc=%b want no overlap",
                 name, cyc, mem_read, mem_write, reg_write, pc_write, pc_write_cond);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_rtype();
    push(4'd0, 1); push(4'd1, 1); push(4'd6, 1); push(4'd7, 1);
    test_instr("rtype", 6'b000000);
  endtask

  task automatic test_lw_stall();
    push(4'd0, 1); push(4'd1, 1); push(4'd2, 1);
    push(4'd3, 0); push(4'd3, 0); push(4'd3, 0); push(4'd3, 1); push(4'd4, 1);
    test_instr("lw", 6'b100011);
  endtask

  task automatic test_sw_beq();
    push(4'd0, 1); push(4'd1, 1); push(4'd2, 1); push(4'd5, 0); push(4'd5, 0); push(4'd5, 1);
    test_instr("sw", 6'b101011);
    push(4'd0, 1); push(4'd1, 1); push(4'd8, 1);
    test_instr("beq", 6'b000100);
  endtask

  task automatic test_j_addiu();
    push(4'd0, 1); push(4'd1, 1); push(4'd9, 1);
    test_instr("j", 6'b000010);
    push(4'd0, 1); push(4'd1, 1); push(4'd10, 1); push(4'd11, 1);
    test_instr("addiu", 6'b001001);
  endtask

  task automatic test_illegal();
    push(4'd0, 1); push(4'd1, 1, 1'b1); push(4'd0, 0);
    test_instr("illegal", 6'b111111);
  endtask

  task automatic test_fetch_stall();
    for (int i = 0; i < 5; i++) push(4'd0, 0);
    push(4'd0, 1); push(4'd1, 1); push(4'd9, 1);
    test_instr("fetch_stall", 6'b000010);
  endtask

  task automatic test_back_to_back();
    push(4'd0, 1); push(4'd1, 1); push(4'd6, 1); push(4'd7, 1);
    test_instr("b2b_r", 6'b000000);
    push(4'd0, 1); push(4'd1, 1); push(4'd2, 1); push(4'd3, 1); push(4'd4, 1);
    test_instr("b2b_lw", 6'b100011);
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_sw_beq();
    test_j_addiu();
    test_illegal();
    test_fetch_stall();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
